// File: rtl/seg_mult_16x16_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_mult_16x16_seq_pkg
// Purpose  : Shared widths and FSM state type for the segmented sequential
//            16x16 unsigned multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package seg_mult_16x16_seq_pkg;

    // Operand width; the datapath is only built for 16-bit operands
    localparam int OP_WIDTH   = 16;
    // Segment width, always half the operand width
    localparam int SEG_WIDTH  = OP_WIDTH / 2;
    // Full product width
    localparam int PROD_WIDTH = 2 * OP_WIDTH;
    // Step counter width (four segment pairs)
    localparam int STEP_WIDTH = 2;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seg_mult_16x16_seq_pkg
`default_nettype wire

// File: rtl/seg_mult_16x16_seq_mult_8x8.sv
`default_nettype none
// ============================================================================
// Module   : mult_8x8
// Purpose  : Combinational 8x8 unsigned multiplier, shared by every step of
//            the segmented 16x16 multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module mult_8x8
    import seg_mult_16x16_seq_pkg::*;
(
    input  logic [SEG_WIDTH-1:0]   in_a,
    input  logic [SEG_WIDTH-1:0]   in_b,
    output logic [2*SEG_WIDTH-1:0] out_8x8
);

    // Single partial-product multiplier, widened to the full 16-bit result
    assign out_8x8 = (2*SEG_WIDTH)'(in_a) * (2*SEG_WIDTH)'(in_b);

endmodule : mult_8x8
`default_nettype wire

// File: rtl/seg_mult_16x16_seq.sv
`default_nettype none
// ============================================================================
// Module   : seg_mult_16x16_seq
// Purpose  : Sequential 16x16 unsigned multiplier. Operands are split into
//            8-bit segments; one 8x8 unit computes the four partial
//            products over four cycles, accumulating into 32 bits.
//            Valid/ready handshake on both input and output sides.
// Revision : 1.0 - initial release
// ============================================================================
module seg_mult_16x16_seq
    import seg_mult_16x16_seq_pkg::*;
#(
    parameter int OP_W  = OP_WIDTH,
    parameter int SEG_W = SEG_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*OP_W-1:0] out_16x16
);

    localparam int PROD_W = 2 * OP_W;

    // Only the 16-bit / 8-bit segment configuration is implemented
    if (OP_W != 16 || SEG_W != OP_W / 2) begin : g_bad_params
        $error("seg_mult_16x16_seq: only OP_W=16, SEG_W=8 is supported");
    end

    state_t                state;
    logic [OP_W-1:0]       a_reg;
    logic [OP_W-1:0]       b_reg;
    logic [PROD_W-1:0]     acc;
    logic [STEP_WIDTH-1:0] step;
    logic [PROD_W-1:0]     prod_reg;
    logic                  in_ready_reg;
    logic                  out_valid_reg;

    logic [SEG_W-1:0]      seg_a;
    logic [SEG_W-1:0]      seg_b;
    logic [2*SEG_W-1:0]    pp;
    logic [PROD_W-1:0]     pp_ext;
    logic [PROD_W-1:0]     pp_shift;
    logic [PROD_W-1:0]     acc_next;

    // Segment select: step[1] picks the high half of a, step[0] the high half of b
    always_comb begin
        seg_a = step[1] ? a_reg[OP_W-1:SEG_W] : a_reg[SEG_W-1:0];
        seg_b = step[0] ? b_reg[OP_W-1:SEG_W] : b_reg[SEG_W-1:0];
    end

    mult_8x8 u_mult_8x8 (
        .in_a    (seg_a),
        .in_b    (seg_b),
        .out_8x8 (pp)
    );

    // Align the partial product by segment weight and add it to the accumulator
    always_comb begin
        pp_ext = {{(PROD_W - 2*SEG_W){1'b0}}, pp};
        case (step)
            2'd0:    pp_shift = pp_ext;
            2'd1,
            2'd2:    pp_shift = pp_ext << SEG_W;
            default: pp_shift = pp_ext << (2*SEG_W);
        endcase
        // Sum of all four terms is at most (2^16-1)^2, so this never wraps
        acc_next = acc + pp_shift;
    end

    // Controller and datapath registers, including the registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            acc           <= '0;
            step          <= '0;
            prod_reg      <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= in_a;
                        b_reg        <= in_b;
                        acc          <= '0;
                        step         <= '0;
                        in_ready_reg <= 1'b0;
                        state        <= CALC;
                    end
                end
                CALC: begin
                    acc  <= acc_next;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        // Last partial product: publish the result on entry to DONE
                        prod_reg      <= acc_next;
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_16x16 = prod_reg;

endmodule : seg_mult_16x16_seq
`default_nettype wire

// File: tb/tb_seg_mult_16x16_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_mult_16x16_seq
// Purpose  : Self-checking bench for seg_mult_16x16_seq: directed corner
//            cases plus randomized operations against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_mult_16x16_seq;

    localparam int LATENCY = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_16x16;

    int          n_checks;
    int          n_pass;
    logic [31:0] last_prod;

    seg_mult_16x16_seq #(
        .OP_W  (16),
        .SEG_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_16x16 (out_16x16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Reference: full-precision unsigned product, truncated to 32 bits
    function automatic logic [31:0] ref_mult(input logic [15:0] a, input logic [15:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return p[31:0];
    endfunction

    // One complete operation. hold = cycles out_ready stays low once valid;
    // disturb = drive fresh in_valid/operands during CALC.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input int hold, input bit disturb);
        logic [31:0] exp;
        int          waited;
        exp    = ref_mult(a, b);
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_val({tag, " ready_before"}, {31'd0, in_ready}, 32'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_val({tag, " in_ready_calc"}, {31'd0, in_ready}, 32'd0);
        for (int k = 1; k <= LATENCY; k++) begin
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            in_valid = disturb ? 1'($urandom) : 1'b0;
            if (disturb && k == 1) in_valid = 1'b1;
            @(negedge clk);
            if (k < LATENCY) begin
                check_val({tag, " out_valid_calc"}, {31'd0, out_valid}, 32'd0);
                check_val({tag, " out_hold_calc"}, out_16x16, last_prod);
            end
        end
        in_valid = 1'b0;
        check_val({tag, " out_valid_done"}, {31'd0, out_valid}, 32'd1);
        check_val({tag, " product"}, out_16x16, exp);
        last_prod = exp;
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(negedge clk);
            check_val({tag, " stall_valid"}, {31'd0, out_valid}, 32'd1);
            check_val({tag, " stall_prod"}, out_16x16, exp);
            check_val({tag, " stall_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val({tag, " out_valid_after"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, " in_ready_after"}, {31'd0, in_ready}, 32'd1);
        check_val({tag, " prod_kept_idle"}, out_16x16, exp);
    endtask

    // Hard stop in case the handshake never progresses
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        last_prod = 32'd0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 16'd0;
        in_b      = 16'd0;
        out_ready = 1'b0;

        // Reset values are visible before any clock edge
        #2;
        check_val("reset in_ready", {31'd0, in_ready}, 32'd1);
        check_val("reset out_valid", {31'd0, out_valid}, 32'd0);
        check_val("reset out_16x16", out_16x16, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op("d1234x5678", 16'h1234, 16'h5678, 0, 1'b0);
        check_val("d1234x5678 const", last_prod, 32'h0626_0060);
        run_op("dFFFFxFFFF", 16'hFFFF, 16'hFFFF, 0, 1'b0);
        check_val("dFFFFxFFFF const", last_prod, 32'hFFFE_0001);
        run_op("d0xABCD", 16'h0000, 16'hABCD, 0, 1'b0);
        run_op("d1xABCD", 16'h0001, 16'hABCD, 0, 1'b0);
        run_op("dstall3", 16'hBEEF, 16'h1357, 3, 1'b0);
        run_op("ddisturb", 16'h8001, 16'h7FFE, 1, 1'b1);

        // Asynchronous reset two edges after acceptance (step 2 of CALC)
        in_a     = 16'hA5A5;
        in_b     = 16'h5A5A;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("abort out_16x16", out_16x16, 32'd0);
        check_val("abort in_ready", {31'd0, in_ready}, 32'd1);
        check_val("abort out_valid", {31'd0, out_valid}, 32'd0);
        last_prod = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("post_abort", 16'hC0DE, 16'h0F0F, 0, 1'b0);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) ra = 16'hFFFF;
            if (i == 1) rb = 16'h0000;
            run_op($sformatf("rnd%0d", i), ra, rb, $urandom_range(0, 3), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_seg_mult_16x16_seq
`default_nettype wire
